motor_bridge_driver: RTL and testbench

- Receiving end of the rover's motor command interface: consumes the 4-bit direction word and 2-bit enable word from the line-following controller.
- Drives the dual H-bridge pins: IN1..IN4 static levels plus PWM on ENA/ENB.
- Guarantees shoot-through-free direction reversal by enforcing a coast dead-time.
- Adds a soft-start duty ramp. Sits between the steering logic and the board pins.

---
 rtl/motor_pkg.sv | 24 ++
 rtl/motor_bridge_channel.sv | 137 +++++++++++++
 rtl/motor_bridge_driver.sv | 77 +++++++
 tb/tb_motor_bridge_driver.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor bridge driver: direction codes, channel
// state encoding and channel indices.
package motor_pkg;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_ILL   = 2'b11;

  localparam int CH_LEFT  = 1;
  localparam int CH_RIGHT = 0;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    DEAD = 2'd1,
    RAMP = 2'd2,
    RUN  = 2'd3
  } ch_state_t;

  function automatic logic is_drive(input logic [1:0] code);
    return (code == DIR_FWD) || (code == DIR_REV);
  endfunction

endpackage

// File: rtl/motor_bridge_channel.sv
// One H-bridge side: OFF/DEAD/RAMP/RUN FSM, dead-time counter, ramp prescaler
// and duty register. Soft-start exists only when MOTOR_RAMP_EN is defined.
module motor_bridge_channel
  import motor_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_MAX    = 200,
  parameter int DEAD_CYCLES = 64,
  parameter int RAMP_STEP   = 4,
  parameter int RAMP_DIV    = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  output ch_state_t           state,
  output logic [1:0]          pins,
  output logic [PWM_BITS-1:0] duty_next
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [PWM_BITS-1:0] DUTY_RUN = PWM_BITS'(DUTY_MAX);

  if (DEAD_CYCLES < 1 || RAMP_DIV < 1 || RAMP_STEP < 1 || DUTY_MAX >= (1 << PWM_BITS))
  begin : g_param_check
    $error("motor_bridge_channel: parameter out of range");
  end

  ch_state_t           state_n;
  logic [1:0]          dir_q, dir_n;
  logic [PWM_BITS-1:0] duty_q;
  logic [DW-1:0]       dead_q, dead_n;
  logic [1:0]          pins_n;

`ifdef MOTOR_RAMP_EN
  localparam int PW = $clog2(RAMP_DIV + 1);
  logic [PW-1:0]     presc_q, presc_n;
  logic [PWM_BITS:0] duty_sum;

  // One extra bit so the step can never wrap past DUTY_MAX
  assign duty_sum = {1'b0, duty_q} + (PWM_BITS + 1)'(RAMP_STEP);
`endif

  always_comb begin
    state_n   = state;
    dir_n     = dir_q;
    duty_next = duty_q;
    dead_n    = dead_q;
`ifdef MOTOR_RAMP_EN
    presc_n   = presc_q;
`endif
    case (state)
      OFF: begin
        if (req != DIR_COAST) begin
          dir_n = req;
`ifdef MOTOR_RAMP_EN
          state_n   = RAMP;
          duty_next = '0;
          presc_n   = '0;
`else
          state_n   = RUN;
          duty_next = DUTY_RUN;
`endif
        end
      end
      DEAD: begin
        if (req == DIR_COAST) begin
          state_n = OFF;
          dir_n   = DIR_COAST;
        end else if (dead_q == DW'(1)) begin
          // Direction is taken from the request at exit, even if it reverted
          dir_n = req;
`ifdef MOTOR_RAMP_EN
          state_n   = RAMP;
          duty_next = '0;
          presc_n   = '0;
`else
          state_n   = RUN;
          duty_next = DUTY_RUN;
`endif
        end else begin
          dead_n = dead_q - DW'(1);
        end
      end
      default: begin
        if (req == DIR_COAST) begin
          state_n   = OFF;
          dir_n     = DIR_COAST;
          duty_next = '0;
        end else if (req != dir_q) begin
          state_n   = DEAD;
          duty_next = '0;
          dead_n    = DW'(DEAD_CYCLES);
        end
`ifdef MOTOR_RAMP_EN
        else if (state == RAMP) begin
          if (presc_q == PW'(RAMP_DIV - 1)) begin
            presc_n = '0;
            if (duty_sum >= {1'b0, DUTY_RUN}) begin
              duty_next = DUTY_RUN;
              state_n   = RUN;
            end else begin
              duty_next = duty_sum[PWM_BITS-1:0];
            end
          end else begin
            presc_n = presc_q + PW'(1);
          end
        end
`endif
      end
    endcase
    pins_n = ((state_n == RAMP) || (state_n == RUN)) ? dir_n : DIR_COAST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OFF;
      dir_q  <= DIR_COAST;
      duty_q <= '0;
      dead_q <= '0;
      pins   <= DIR_COAST;
    end else begin
      state  <= state_n;
      dir_q  <= dir_n;
      duty_q <= duty_next;
      dead_q <= dead_n;
      pins   <= pins_n;
    end
  end

`ifdef MOTOR_RAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_n;
  end
`endif

endmodule

// File: rtl/motor_bridge_driver.sv
// Dual H-bridge driver: registered command inputs, shared PWM counter, two
// dead-time protected channels and sticky fault. Soft-start via MOTOR_RAMP_EN.
module motor_bridge_driver
  import motor_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_MAX    = 200,
  parameter int DEAD_CYCLES = 64,
  parameter int RAMP_STEP   = 4,
  parameter int RAMP_DIV    = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] motor_in,
  input  logic [1:0] motor_en,
  output logic [3:0] bridge_in,
  output logic [1:0] bridge_pwm,
  output logic [1:0] busy,
  output logic       fault
);

  logic [3:0]          dir_q;
  logic [1:0]          en_q;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_n;
  logic [1:0]          ill;
  logic [1:0]          pwm_n;
  ch_state_t           ch_state [2];
  logic [PWM_BITS-1:0] duty_next [2];

  assign pwm_cnt_n = pwm_cnt + PWM_BITS'(1);

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [1:0] code;
    logic [1:0] req;

    assign code    = dir_q[2*ch+1 -: 2];
    assign req     = (en_q[ch] && is_drive(code)) ? code : DIR_COAST;
    assign ill[ch] = en_q[ch] && (code == DIR_ILL);

    motor_bridge_channel #(
      .PWM_BITS   (PWM_BITS),
      .DUTY_MAX   (DUTY_MAX),
      .DEAD_CYCLES(DEAD_CYCLES),
      .RAMP_STEP  (RAMP_STEP),
      .RAMP_DIV   (RAMP_DIV)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .state    (ch_state[ch]),
      .pins     (bridge_in[2*ch+1 -: 2]),
      .duty_next(duty_next[ch])
    );

    // Compare next counter against next duty so the registered pin equals
    // (pwm_cnt < duty) for the current register values
    assign pwm_n[ch] = (pwm_cnt_n < duty_next[ch]);
    assign busy[ch]  = (ch_state[ch] == DEAD) || (ch_state[ch] == RAMP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= '0;
      en_q       <= '0;
      pwm_cnt    <= '0;
      bridge_pwm <= '0;
      fault      <= 1'b0;
    end else begin
      dir_q      <= motor_in;
      en_q       <= motor_en;
      pwm_cnt    <= pwm_cnt_n;
      bridge_pwm <= pwm_n;
      fault      <= fault | (|ill);
    end
  end

endmodule

// File: tb/tb_motor_bridge_driver.sv
// Self-checking bench for motor_bridge_driver: vector table, hand-written
// dead-time / PWM / async-reset sequences and a randomized model comparison.
module tb_motor_bridge_driver;

  localparam int PWM_BITS    = 8;
  localparam int DUTY_MAX    = 200;
  localparam int DEAD_CYCLES = 4;
  localparam int RAMP_STEP   = 50;
  localparam int RAMP_DIV    = 2;
  localparam int W           = 9;
`ifdef MOTOR_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] motor_in = '0;
  logic [1:0] motor_en = '0;
  logic [3:0] bridge_in;
  logic [1:0] bridge_pwm;
  logic [1:0] busy;
  logic       fault;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  motor_bridge_driver #(
    .PWM_BITS   (PWM_BITS),
    .DUTY_MAX   (DUTY_MAX),
    .DEAD_CYCLES(DEAD_CYCLES),
    .RAMP_STEP  (RAMP_STEP),
    .RAMP_DIV   (RAMP_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .motor_in  (motor_in),
    .motor_en  (motor_en),
    .bridge_in (bridge_in),
    .bridge_pwm(bridge_pwm),
    .busy      (busy),
    .fault     (fault)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n    = 1'b0;
    motor_in = '0;
    motor_en = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [3:0] mi, input logic [1:0] me);
    @(negedge clk);
    motor_in = mi;
    motor_en = me;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // A channel is either off, coasting out a dead-time, or driving; while
  // driving its duty follows from how long it has been driving.
  logic [3:0] m_cmd;
  logic [1:0] m_en;
  int ch_on [2];
  int ch_dir [2];
  int ch_dead [2];
  int ch_age [2];
  int m_cnt;
  bit m_fault;

  task automatic model_reset();
    m_cmd = '0; m_en = '0; m_cnt = 0; m_fault = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      ch_on[ch] = 0; ch_dir[ch] = 0; ch_dead[ch] = 0; ch_age[ch] = 0;
    end
  endtask

  function automatic int model_duty(input int ch);
    int d;
    if (ch_on[ch] == 0 || ch_dead[ch] > 0) return 0;
    if (!RAMP_ON) return DUTY_MAX;
    d = RAMP_STEP * (ch_age[ch] / RAMP_DIV);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  task automatic model_step();
    for (int ch = 0; ch < 2; ch++) begin
      logic [1:0] code;
      int r;
      code = m_cmd[2*ch+1 -: 2];
      r = 0;
      if (m_en[ch] && code == 2'b11) m_fault = 1'b1;
      if (m_en[ch] && (code == 2'b10 || code == 2'b01)) r = int'(code);
      if (r == 0) begin
        ch_on[ch] = 0; ch_dead[ch] = 0;
      end else if (ch_on[ch] == 0) begin
        ch_on[ch] = 1; ch_dir[ch] = r; ch_age[ch] = 0;
      end else if (ch_dead[ch] > 0) begin
        ch_dead[ch]--;
        if (ch_dead[ch] == 0) begin
          ch_dir[ch] = r; ch_age[ch] = 0;
        end
      end else if (r != ch_dir[ch]) begin
        ch_dead[ch] = DEAD_CYCLES;
      end else if (ch_age[ch] < 100000) begin
        ch_age[ch]++;
      end
    end
    m_cnt = (m_cnt + 1) % 256;
    m_cmd = motor_in;
    m_en  = motor_en;
  endtask

  function automatic logic [W-1:0] model_word();
    logic [3:0] bi;
    logic [1:0] pw;
    logic [1:0] bs;
    int d;
    bit drv;
    bi = '0; pw = '0; bs = '0;
    for (int ch = 0; ch < 2; ch++) begin
      d   = model_duty(ch);
      drv = (ch_on[ch] != 0) && (ch_dead[ch] == 0);
      if (drv) bi[2*ch+1 -: 2] = 2'(ch_dir[ch]);
      pw[ch] = (m_cnt < d);
      bs[ch] = (ch_dead[ch] > 0) || (RAMP_ON && drv && d < DUTY_MAX);
    end
    return {bi, pw, bs, m_fault};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step();
        exp_q.push_back(model_word());
      end
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("model", {bridge_in, bridge_pwm, busy, fault}, e);
      end
    end
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL timeout: simulation did not finish, expected done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] mi;
    logic [1:0] me;
    int         hold;
    logic [3:0] bi;
    logic [1:0] bs;
    logic       ft;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [1:0] rb;
    int hi_l, hi_r;
    logic [1:0] exp_left;
    rb = RAMP_ON ? 2'b11 : 2'b00;
    vecs[0]  = '{4'b1010, 2'b11, 1, 4'b0000, 2'b00, 1'b0};
    vecs[1]  = '{4'b1010, 2'b11, 1, 4'b1010, rb, 1'b0};
    vecs[2]  = '{4'b1010, 2'b11, 8, 4'b1010, 2'b00, 1'b0};
    vecs[3]  = '{4'b1010, 2'b10, 2, 4'b1000, 2'b00, 1'b0};
    vecs[4]  = '{4'b1011, 2'b10, 2, 4'b1000, 2'b00, 1'b0};
    vecs[5]  = '{4'b1011, 2'b11, 2, 4'b1000, 2'b00, 1'b1};
    vecs[6]  = '{4'b1001, 2'b11, 2, 4'b1001, {1'b0, RAMP_ON}, 1'b1};
    vecs[7]  = '{4'b0101, 2'b11, 2, 4'b0001, {1'b1, RAMP_ON}, 1'b1};
    vecs[8]  = '{4'b0101, 2'b11, 4, 4'b0101, rb, 1'b1};
    vecs[9]  = '{4'b0000, 2'b11, 2, 4'b0000, 2'b00, 1'b1};
    vecs[10] = '{4'b0110, 2'b00, 3, 4'b0000, 2'b00, 1'b1};

    do_reset();
    check("reset_bridge_in", {28'd0, bridge_in}, 32'd0);
    check("reset_pwm_busy_fault", {27'd0, bridge_pwm, busy, fault}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].mi, vecs[i].me);
      wait_clk(vecs[i].hold);
      check($sformatf("vec%0d_bridge_in", i), {28'd0, bridge_in}, {28'd0, vecs[i].bi});
      check($sformatf("vec%0d_busy", i), {30'd0, busy}, {30'd0, vecs[i].bs});
      check($sformatf("vec%0d_fault", i), {31'd0, fault}, {31'd0, vecs[i].ft});
    end

    // PWM duty over a full counter period once both sides are at full run
    do_reset();
    apply(4'b1010, 2'b11);
    wait_clk(12);
    hi_l = 0; hi_r = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi_l += int'(bridge_pwm[1]);
      hi_r += int'(bridge_pwm[0]);
    end
    check("pwm_high_left", hi_l, DUTY_MAX);
    check("pwm_high_right", hi_r, DUTY_MAX);
    check("run_busy", {30'd0, busy}, 32'd0);

    // Left reversal: exactly DEAD_CYCLES of coast, right side untouched
    apply(4'b0110, 2'b11);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_left = (k == 1) ? 2'b10 : ((k <= 5) ? 2'b00 : 2'b01);
      check($sformatf("rev_k%0d_bridge_in", k), {28'd0, bridge_in}, {28'd0, exp_left, 2'b10});
      if (k >= 2 && k <= 5) begin
        check($sformatf("rev_k%0d_pwm_left", k), {31'd0, bridge_pwm[1]}, 32'd0);
        check($sformatf("rev_k%0d_busy_left", k), {31'd0, busy[1]}, 32'd1);
      end
      if (k == 6) check("rev_exit_busy_left", {31'd0, busy[1]}, {31'd0, RAMP_ON});
    end

    // Asynchronous reset in the middle of a dead-time
    apply(4'b1010, 2'b11);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bridge_in", {28'd0, bridge_in}, 32'd0);
    check("async_rst_pwm_busy_fault", {27'd0, bridge_pwm, busy, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(1);
    check("post_rst_c1", {28'd0, bridge_in}, 32'd0);
    wait_clk(1);
    check("post_rst_c2_no_dead", {28'd0, bridge_in}, 32'h0000000a);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        for (int ch = 0; ch < 2; ch++) begin
          int c;
          c = $urandom_range(0, 9);
          motor_in[2*ch+1 -: 2] = (c < 4) ? 2'b10 : ((c < 8) ? 2'b01 : ((c < 9) ? 2'b00 : 2'b11));
        end
        motor_en = 2'($urandom_range(0, 3));
      end
      if (i == 1500) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    wait_clk(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
